// File: rtl/pulse_meas_if.sv
// pulse_meas_if: one-entry result channel from pulse_meas to its consumer.
//   meas_valid  producer -> consumer  a result is held
//   meas_ready  consumer -> producer  result taken when valid && ready
//   meas_level  producer -> consumer  level of the measured segment (1 = high)
//   meas_width  producer -> consumer  segment length in clk cycles
//   meas_sat    producer -> consumer  segment overflowed the counter (width all ones)
interface pulse_meas_if #(
  parameter int P_CNT_W = 24
) ();
  logic               meas_valid;
  logic               meas_ready;
  logic               meas_level;
  logic [P_CNT_W-1:0] meas_width;
  logic               meas_sat;

  modport master (
    output meas_valid, meas_level, meas_width, meas_sat,
    input  meas_ready
  );

  modport slave (
    input  meas_valid, meas_level, meas_width, meas_sat,
    output meas_ready
  );
endinterface

// File: rtl/pulse_meas.sv
// pulse_meas: measures high/low segment widths of the filtered, idle-high din.
//   clk, rst_n   system clock, async active-low reset
//   en           level-sensitive measurement enable
//   din          filtered input, synchronous to clk, idles high
//   rise_pulse   1-cycle strobe per rising edge of din while enabled
//   fall_pulse   1-cycle strobe per falling edge of din while enabled
//   m            result channel (valid/ready, level, width, sat)
//   drop_cnt     saturating count of results lost to a full output register
//   busy         FSM is in ARM or MEAS
module pulse_meas #(
  parameter int P_CNT_W  = 24,
  parameter int P_DROP_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                din,
  output logic                rise_pulse,
  output logic                fall_pulse,
  pulse_meas_if.master        m,
  output logic [P_DROP_W-1:0] drop_cnt,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  typedef struct packed {
    logic               level;
    logic               sat;
    logic [P_CNT_W-1:0] width;
  } res_t;

  localparam logic [P_CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [P_CNT_W-1:0]  CNT_ONE  = P_CNT_W'(1);
  localparam logic [P_DROP_W-1:0] DROP_MAX = '1;
  localparam logic [P_DROP_W-1:0] DROP_ONE = P_DROP_W'(1);

  state_t             state;
  logic               d_q, d_qq;
  logic [P_CNT_W-1:0] cnt;
  res_t               res_q;
  logic               valid_q;

  logic               edge_det;
  logic               active;
  logic               new_res;
  logic               accept;
  res_t               res_new;

  // Two-deep sample history. Both reset high so an idle-high din produces
  // no edge after reset. An edge is judged on registered samples, which puts
  // strobes and results one cycle after the sampling clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q  <= 1'b1;
      d_qq <= 1'b1;
    end else begin
      d_q  <= din;
      d_qq <= d_q;
    end
  end

  always_comb begin
    edge_det      = d_q ^ d_qq;
    active        = en && (state != IDLE);
    new_res       = en && (state == MEAS) && edge_det;
    accept        = valid_q && m.meas_ready;
    // d_qq is the last sample of the segment that the current edge closes.
    res_new.level = d_qq;
    res_new.sat   = (cnt == CNT_MAX);
    res_new.width = cnt;
  end

  // Control FSM with registered strobes and busy. The counter is loaded
  // with 1 on the edge that opens a segment and counts every following
  // sample, so it holds B-A when the closing edge at B is processed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= active && edge_det && d_q;
      fall_pulse <= active && edge_det && !d_q;
      // Next state is non-IDLE exactly when en is high.
      busy       <= en;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (en) state <= ARM;
        end
        ARM: begin
          if (!en) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (edge_det) begin
            // Length of the segment before the first edge is unknown: no result.
            state <= MEAS;
            cnt   <= CNT_ONE;
          end
        end
        MEAS: begin
          if (!en) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (edge_det) begin
            cnt <= CNT_ONE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // One-entry output register. A result arriving in the same cycle the held
  // one is accepted replaces it without a bubble; otherwise a full register
  // keeps its contents and the newcomer is counted as dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      res_q    <= '0;
      drop_cnt <= '0;
    end else begin
      if (new_res && (!valid_q || accept)) begin
        res_q   <= res_new;
        valid_q <= 1'b1;
      end else if (new_res) begin
        if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + DROP_ONE;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign m.meas_valid = valid_q;
  assign m.meas_level = res_q.level;
  assign m.meas_width = res_q.width;
  assign m.meas_sat   = res_q.sat;
endmodule

// File: tb/tb_pulse_meas.sv
// tb_pulse_meas: self-checking bench for pulse_meas with a 4-bit counter.
// Expected results are queued when the closing edge is driven and compared
// by a negedge monitor whenever the DUT hands a result over.
module tb_pulse_meas;
  localparam int CW   = 4;
  localparam int DW   = 16;
  localparam int MAXW = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          din = 1'b1;
  logic          ready = 1'b0;
  logic          rise_pulse, fall_pulse, busy;
  logic [DW-1:0] drop_cnt;

  pulse_meas_if #(.P_CNT_W(CW)) m_if ();
  assign m_if.meas_ready = ready;

  pulse_meas #(.P_CNT_W(CW), .P_DROP_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .din        (din),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .m          (m_if),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          lvl;
    logic          sat;
    logic [CW-1:0] w;
  } exp_t;

  typedef struct {
    logic          lvl;
    int            len;
    logic [CW-1:0] exp_w;
    logic          exp_sat;
    bit            rep;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: strobe counters, valid-rise tracking, scoreboard on handover.
  int   n_rise = 0, n_fall = 0, n_vrise = 0, fall_cyc = -1;
  logic v_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e, g;
    if (rise_pulse === 1'b1) n_rise++;
    if (fall_pulse === 1'b1) begin n_fall++; fall_cyc = cyc; end
    if (m_if.meas_valid === 1'b1 && !v_prev) n_vrise++;
    v_prev = (m_if.meas_valid === 1'b1);
    if (m_if.meas_valid === 1'b1 && ready) begin
      total++;
      g = {m_if.meas_level, m_if.meas_sat, m_if.meas_width};
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: got lvl=%0d sat=%0d w=%0d, required no result", g.lvl, g.sat, g.w);
      end else begin
        e = sb.pop_front();
        if (g !== e)
          begin
            bad++;
            $display("FAIL sb_result: got lvl=%0d sat=%0d w=%0d, required lvl=%0d sat=%0d w=%0d",
                     g.lvl, g.sat, g.w, e.lvl, e.sat, e.w);
          end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  function automatic void push_raw(input logic lvl, input logic sat, input logic [CW-1:0] w);
    exp_t e;
    e.lvl = lvl; e.sat = sat; e.w = w;
    sb.push_back(e);
  endfunction

  // Expected result for a run of len samples at level lvl.
  function automatic void push(input logic lvl, input int len);
    push_raw(lvl, len >= MAXW, (len >= MAXW) ? CW'(MAXW) : CW'(len));
  endfunction

  // Level and sample count of the din run currently being driven.
  logic cur = 1'b1;
  int   run = 1000;

  // Drive din=v for n samples; with rep set, the run this change closes is
  // expected to be reported.
  task automatic hold(input logic v, input int n, input bit rep);
    if (v !== cur) begin
      if (rep) push(cur, run);
      cur = v;
      run = 0;
    end
    din = v;
    repeat (n) begin
      @(posedge clk);
      #1;
      run++;
    end
  endtask

  initial begin
    vec_t tbl[11];
    int   er, ef, nr0, nf0, c0, vr0;

    tbl[0]  = '{1'b1,  2, 4'd4,  1'b0, 1'b1};  // extends the high run already open
    tbl[1]  = '{1'b0,  1, 4'd1,  1'b0, 1'b1};  // minimum width
    tbl[2]  = '{1'b1,  1, 4'd1,  1'b0, 1'b1};
    tbl[3]  = '{1'b0,  3, 4'd3,  1'b0, 1'b1};
    tbl[4]  = '{1'b1, 40, 4'd15, 1'b1, 1'b1};  // overflows the counter
    tbl[5]  = '{1'b0,  3, 4'd3,  1'b0, 1'b1};  // recovers after saturation
    tbl[6]  = '{1'b1, 15, 4'd15, 1'b1, 1'b1};  // exactly reaches the max
    tbl[7]  = '{1'b0, 14, 4'd14, 1'b0, 1'b1};
    tbl[8]  = '{1'b1,  2, 4'd2,  1'b0, 1'b1};
    tbl[9]  = '{1'b0,  4, 4'd4,  1'b0, 1'b1};
    tbl[10] = '{1'b1,  3, 4'd0,  1'b0, 1'b0};  // left open

    // Reset state
    rst_n = 1'b0; en = 1'b1; din = 1'b1; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", m_if.meas_valid, 0);
    chk("rst_level", m_if.meas_level, 0);
    chk("rst_width", m_if.meas_width, 0);
    chk("rst_sat",   m_if.meas_sat, 0);
    chk("rst_drop",  drop_cnt, 0);
    chk("rst_rise",  rise_pulse, 0);
    chk("rst_fall",  fall_pulse, 0);
    chk("rst_busy",  busy, 0);
    rst_n = 1'b1;

    // Idle-high after release: no edges, no results
    hold(1'b1, 100, 1'b0);
    chk("idle_rise_cnt", n_rise, 0);
    chk("idle_fall_cnt", n_fall, 0);
    chk("idle_valid_cnt", n_vrise, 0);
    chk("idle_busy", busy, 1);

    // First edge arms only; second edge reports a 5-cycle low
    c0 = cyc;
    hold(1'b0, 5, 1'b0);
    chk("t2_fall_cycle", fall_cyc, c0 + 2);
    chk("t2_first_edge_no_result", n_vrise, 0);
    hold(1'b1, 2, 1'b1);
    chk("t2_rise_pulse", rise_pulse, 1);
    chk("t2_valid", m_if.meas_valid, 1);
    chk("t2_level", m_if.meas_level, 0);
    chk("t2_width", m_if.meas_width, 5);

    // Table of segments with the consumer always ready
    er = 0; ef = 0; nr0 = 0; nf0 = 0;
    for (int i = 0; i < 11; i++) begin
      if (i == 1) begin nr0 = n_rise; nf0 = n_fall; end
      if (i > 0) begin
        if (tbl[i-1].rep) push_raw(tbl[i-1].lvl, tbl[i-1].exp_sat, tbl[i-1].exp_w);
        if (tbl[i].lvl) er++; else ef++;
      end
      hold(tbl[i].lvl, tbl[i].len, 1'b0);
    end
    chk("tbl_rise_cnt", n_rise - nr0, er);
    chk("tbl_fall_cnt", n_fall - nf0, ef);
    chk("tbl_drained", sb.size(), 0);
    chk("tbl_no_drop", drop_cnt, 0);

    // Enable dropped with a pending result and a segment in progress
    ready = 1'b0;
    hold(1'b0, 2, 1'b1);
    chk("en_pending_valid", m_if.meas_valid, 1);
    en = 1'b0;
    chk("en_busy_before", busy, 1);
    hold(1'b0, 1, 1'b0);
    chk("en_busy_after", busy, 0);
    nr0 = n_rise;
    hold(1'b1, 3, 1'b0);
    chk("en_idle_no_strobe", n_rise - nr0, 0);
    chk("en_pending_kept", m_if.meas_valid, 1);
    chk("en_pending_width", m_if.meas_width, 3);
    chk("en_pending_level", m_if.meas_level, 1);
    ready = 1'b1;
    hold(1'b1, 1, 1'b0);
    chk("en_pending_taken", m_if.meas_valid, 0);
    en = 1'b1;
    hold(1'b1, 1, 1'b0);
    chk("en_busy_again", busy, 1);
    nf0 = n_fall;
    hold(1'b0, 3, 1'b0);
    chk("en_rearm_strobe", n_fall - nf0, 1);
    chk("en_rearm_no_result", m_if.meas_valid, 0);
    hold(1'b1, 3, 1'b1);
    chk("en_drained", sb.size(), 0);

    // Full output register with consumer stalled: drops counted
    en = 1'b0;
    hold(1'b1, 1, 1'b0);
    en = 1'b1;
    hold(1'b1, 2, 1'b0);
    ready = 1'b0;
    hold(1'b0, 2, 1'b0);
    hold(1'b1, 2, 1'b1);
    chk("drop_first_valid", m_if.meas_valid, 1);
    chk("drop_first_zero", drop_cnt, 0);
    for (int k = 1; k <= 5; k++) begin
      hold((k % 2) ? 1'b0 : 1'b1, 2, 1'b0);
      chk("drop_count", drop_cnt, k);
      chk("drop_held_width", m_if.meas_width, 2);
      chk("drop_held_level", m_if.meas_level, 0);
    end
    ready = 1'b1;
    hold(1'b0, 1, 1'b0);
    chk("drop_cleared_valid", m_if.meas_valid, 0);
    chk("drop_final", drop_cnt, 5);

    // New result in the same cycle as an accept
    ready = 1'b0;
    hold(1'b1, 2, 1'b1);
    chk("same_held_valid", m_if.meas_valid, 1);
    push(1'b1, 2);
    din = 1'b0; cur = 1'b0; run = 0;
    @(posedge clk); #1; run = 1;
    ready = 1'b1;
    @(posedge clk); #1; run = 2;
    chk("same_valid", m_if.meas_valid, 1);
    chk("same_width", m_if.meas_width, 2);
    chk("same_level", m_if.meas_level, 1);
    chk("same_drop", drop_cnt, 5);
    hold(1'b0, 2, 1'b0);
    chk("same_drained", sb.size(), 0);
    chk("same_valid_clear", m_if.meas_valid, 0);

    // Reset with a pending result: lost, nothing until a new edge pair
    ready = 1'b0;
    hold(1'b1, 3, 1'b0);
    chk("mrst_pending", m_if.meas_valid, 1);
    rst_n = 1'b0;
    #2;
    chk("mrst_valid", m_if.meas_valid, 0);
    chk("mrst_width", m_if.meas_width, 0);
    chk("mrst_drop", drop_cnt, 0);
    chk("mrst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready = 1'b1;
    vr0 = n_vrise;
    hold(1'b1, 3, 1'b0);
    hold(1'b0, 3, 1'b0);
    chk("mrst_no_output", n_vrise - vr0, 0);
    hold(1'b1, 2, 1'b1);
    hold(1'b1, 2, 1'b0);
    chk("mrst_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
